// File: rtl/gpp_comm_pkg.sv
// gpp_comm_pkg: shared constants, RX entry layout and arbiter states for the GPP/CP bridge
package gpp_comm_pkg;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 8;
    localparam int NUM_CH = 4;
    localparam int CH_W   = $clog2(NUM_CH);
    typedef struct packed {
        logic [CH_W-1:0]   ch;
        logic [DATA_W-1:0] data;
    } rx_entry_t;
    typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;
endpackage

// File: rtl/gpp_comm_if.sv
// gpp_comm_if: TX/RX handshake bundle; master is the GPP/CP environment, slave is the bridge
interface gpp_comm_if #(
    parameter int DATA_W = gpp_comm_pkg::DATA_W,
    parameter int NUM_CH = gpp_comm_pkg::NUM_CH
);
    localparam int CH_W = $clog2(NUM_CH);
    logic              gpp_tx_valid, gpp_tx_ready;
    logic [CH_W-1:0]   gpp_tx_ch;
    logic [DATA_W-1:0] gpp_tx_data;
    logic              cp_tx_valid, cp_tx_ready;
    logic [CH_W-1:0]   cp_tx_ch;
    logic [DATA_W-1:0] cp_tx_data;
    logic              cp_rx_flag;
    logic [CH_W-1:0]   cp_rx_ch;
    logic [DATA_W-1:0] cp_rx_data;
    logic              gpp_rtr, gpp_rx_valid, gpp_rx_ready;
    logic [CH_W-1:0]   gpp_rx_ch;
    logic [DATA_W-1:0] gpp_rx_data;
    modport master (
        output gpp_tx_valid, gpp_tx_ch, gpp_tx_data, cp_tx_ready,
               cp_rx_flag, cp_rx_ch, cp_rx_data, gpp_rx_ready,
        input  gpp_tx_ready, cp_tx_valid, cp_tx_ch, cp_tx_data,
               gpp_rtr, gpp_rx_valid, gpp_rx_ch, gpp_rx_data
    );
    modport slave (
        input  gpp_tx_valid, gpp_tx_ch, gpp_tx_data, cp_tx_ready,
               cp_rx_flag, cp_rx_ch, cp_rx_data, gpp_rx_ready,
        output gpp_tx_ready, cp_tx_valid, cp_tx_ch, cp_tx_data,
               gpp_rtr, gpp_rx_valid, gpp_rx_ch, gpp_rx_data
    );
endinterface

// File: rtl/gpp_comm_fifo.sv
// gpp_comm_fifo: registered-head synchronous FIFO; flush discards contents and any same-cycle push/pop
module gpp_comm_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;
    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign dout    = mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/gpp_comm_bridge.sv
// gpp_comm_bridge: per-channel TX FIFOs drained round-robin to the CP, plus a shared tagged RX FIFO
module gpp_comm_bridge
    import gpp_comm_pkg::*;
#(
    parameter int DATA_W = gpp_comm_pkg::DATA_W,
    parameter int DEPTH  = gpp_comm_pkg::DEPTH,
    parameter int NUM_CH = gpp_comm_pkg::NUM_CH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   clr_err,
    gpp_comm_if.slave              bus,
    output logic                   rx_overflow,
    output logic [NUM_CH-1:0]      tx_ch_full,
    output logic [$clog2(DEPTH):0] rx_level
);
    localparam int CH_W = $clog2(NUM_CH);
    localparam int RW   = CH_W + DATA_W;
    logic [NUM_CH-1:0] tx_empty, tx_push, tx_pop;
    logic [DATA_W-1:0] tx_head [NUM_CH];
    logic [CH_W-1:0]   ptr, lock_ch, sel, idx;
    logic              found, hs;
    arb_state_t        state;
    logic [RW-1:0]     rx_head;
    logic              rx_full, rx_empty;
    assign hs = state == ARB_LOCKED && bus.cp_tx_ready;
    assign bus.gpp_tx_ready = !tx_ch_full[bus.gpp_tx_ch];
    for (genvar g = 0; g < NUM_CH; g++) begin : g_tx
        logic [$clog2(DEPTH):0] unused_cnt;
        assign tx_push[g] = bus.gpp_tx_valid && bus.gpp_tx_ch == CH_W'(g) && !tx_ch_full[g];
        assign tx_pop[g]  = hs && lock_ch == CH_W'(g);
        gpp_comm_fifo #(.W(DATA_W), .DEPTH(DEPTH)) u_fifo (
            .clk(clk), .rst(rst), .flush(flush),
            .push(tx_push[g]), .pop(tx_pop[g]), .din(bus.gpp_tx_data),
            .dout(tx_head[g]), .full(tx_ch_full[g]), .empty(tx_empty[g]),
            .count(unused_cnt)
        );
    end
    // Scan downward so the channel closest above the pointer wins
    always_comb begin
        found = 1'b0;
        sel   = ptr;
        idx   = ptr;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            idx = ptr + CH_W'(i);
            if (!tx_empty[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ARB_IDLE;
            ptr     <= '0;
            lock_ch <= '0;
        end else if (flush) begin
            state <= ARB_IDLE;
        end else if (state == ARB_IDLE) begin
            if (found) begin
                state   <= ARB_LOCKED;
                lock_ch <= sel;
            end
        end else if (bus.cp_tx_ready) begin
            state <= ARB_IDLE;
            ptr   <= lock_ch + CH_W'(1);
        end
    end
    assign bus.cp_tx_valid = state == ARB_LOCKED;
    assign bus.cp_tx_ch    = bus.cp_tx_valid ? lock_ch : '0;
    assign bus.cp_tx_data  = bus.cp_tx_valid ? tx_head[lock_ch] : '0;
    gpp_comm_fifo #(.W(RW), .DEPTH(DEPTH)) u_rx_fifo (
        .clk(clk), .rst(rst), .flush(flush),
        .push(bus.cp_rx_flag), .pop(bus.gpp_rx_ready),
        .din({bus.cp_rx_ch, bus.cp_rx_data}),
        .dout(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_level)
    );
    assign bus.gpp_rtr      = !rx_full;
    assign bus.gpp_rx_valid = !rx_empty;
    assign bus.gpp_rx_ch    = bus.gpp_rx_valid ? rx_head[RW-1:DATA_W] : '0;
    assign bus.gpp_rx_data  = bus.gpp_rx_valid ? rx_head[DATA_W-1:0] : '0;
    always_ff @(posedge clk) begin
        if (rst) rx_overflow <= 1'b0;
        else if (bus.cp_rx_flag && rx_full && !flush) rx_overflow <= 1'b1;
        else if (clr_err) rx_overflow <= 1'b0;
    end
endmodule
